spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have parameter SPI_DATA_WIDTH, default 8, bits per word (2..32).
REQ-002 SHALL have parameter CPOL, default 0, idle level of p_clk.
REQ-003 SHALL have parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have port clk, input, 1, system clock; the only clock.
REQ-005 SHALL have port async_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port p_clk, input, 1, SPI clock from controller, asynchronous to clk.
REQ-007 SHALL have port p_sel_n, input, 1, active-low chip select from controller, asynchronous.
REQ-008 SHALL have port copi, input, 1, controller out, peripheral in, asynchronous.
REQ-009 SHALL have port poci, output, 1, peripheral out, controller in.
REQ-010 SHALL have port poci_oe, output, 1, output enable for poci; high only while selected.
REQ-011 SHALL have port tx_data, input, SPI_DATA_WIDTH, next word to transmit.
REQ-012 SHALL have port tx_wr, input, 1, write strobe for tx_data.
REQ-013 SHALL have port tx_ready, output, 1, TX holding buffer empty.
REQ-014 SHALL have port rx_data, output, SPI_DATA_WIDTH, last received word.
REQ-015 SHALL have port rx_valid, output, 1, rx_data unread.
REQ-016 SHALL have port rx_ack, input, 1, consumer has read rx_data.
REQ-017 SHALL have port busy, output, 1, in ACTIVE state.

Function
REQ-018 SHALL pass p_clk, p_sel_n and copi through 2-flop synchronizers, then detect p_clk edges against a third registered copy; requires p_clk half-period >= 4 clk cycles.
REQ-019 SHALL run FSM IDLE -> ACTIVE on synchronized p_sel_n falling; ACTIVE -> IDLE on synchronized p_sel_n rising; no other states.
REQ-020 SHALL define leading edge as p_clk leaving CPOL level, trailing edge as returning to it.
REQ-021 SHALL shift MSB first for both directions.
REQ-022 SHALL, at word start (IDLE->ACTIVE, or after last bit of a word with p_sel_n still low), load TX shift register from holding buffer if full, else all-zeros; loading empties buffer, tx_ready rises next cycle.
REQ-023 SHALL with CPHA=0 drive MSB on poci at word start, sample copi on leading edges, shift next bit out on trailing edges.
REQ-024 SHALL with CPHA=1 shift out on leading edges (first leading edge presents MSB), sample copi on trailing edges.
REQ-025 SHALL count sampled bits modulo SPI_DATA_WIDTH; on the SPI_DATA_WIDTH-th sample, copy the RX shift register into rx_data and set rx_valid on the next clk.
REQ-026 SHALL clear rx_valid on clk after rx_ack high; rx_ack while rx_valid low is ignored; completion and rx_ack same cycle -> rx_valid stays high with new data.
REQ-027 SHALL accept tx_wr only when tx_ready high (tx_ready drops next cycle); tx_wr when tx_ready low is ignored.
REQ-028 SHALL, on p_sel_n rising mid-word, discard partial RX bits, reset bit counter, not assert rx_valid, not reload TX.
REQ-029 SHALL hold poci_oe high and busy high exactly while in ACTIVE; poci drives 0 when poci_oe low.

Reset
REQ-030 SHALL on async_rst clear immediately, independent of clk: FSM to IDLE, shift registers, bit counter, rx_data to 0, rx_valid 0, tx_ready 1, poci 0, poci_oe 0, busy 0, synchronizers to inactive levels (p_sel_n 1, p_clk CPOL).
REQ-031 SHALL, on reset deassertion with p_sel_n already low, wait for a fresh synchronized falling edge before entering ACTIVE.

Configuration
REQ-032 SHALL, with macro SPI_PERIPHERAL_OVERRUN_EN defined, add output port overrun (1 bit, reset 0), set sticky when a word completes while rx_valid high and rx_ack low, cleared by rx_ack; new data overwrites rx_data regardless.
REQ-033 SHALL, without SPI_PERIPHERAL_OVERRUN_EN, omit the overrun port and logic; overwrite behaviour unchanged.

Verification
REQ-034 SHALL test mode 0, 8-bit: tx_wr 0xA5, controller sends 0x3C -> rx_data 0x3C with rx_valid, controller captures 0xA5, tx_ready back to 1.
REQ-035 SHALL test CPOL=1 CPHA=1: two back-to-back words 0x81, 0x7E under one select with buffer refilled -> two rx_valid events, correct values both ways.
REQ-036 SHALL test empty TX buffer: no tx_wr, 1 word clocked -> controller captures 0x00.
REQ-037 SHALL test abort: p_sel_n rises after 5 bits -> no rx_valid, next full word 0xC3 received correctly.
REQ-038 SHALL test async_rst mid-word -> all outputs at reset values within same cycle, tx_ready 1.
REQ-039 SHALL test with SPI_PERIPHERAL_OVERRUN_EN: two words without rx_ack -> overrun 1, rx_data equals second word; rx_ack clears both.

Source files
------------

// File: rtl/spi_peripheral_if.sv
// Host-side word interface of the SPI peripheral: TX holding buffer, RX word, status.
interface spi_peripheral_if #(
    parameter int SPI_DATA_WIDTH = 8
);
    logic [SPI_DATA_WIDTH-1:0] tx_data;
    logic                      tx_wr;
    logic                      tx_ready;
    logic [SPI_DATA_WIDTH-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ack;
    logic                      busy;

    modport master (
        output tx_data, tx_wr, rx_ack,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_wr, rx_ack,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_peripheral.sv
// SPI peripheral oversampled on clk: synchronised pins, MSB-first shift, one-word TX/RX buffering.
// Optional SPI_PERIPHERAL_OVERRUN_EN adds a sticky overrun flag output.
module spi_peripheral #(
    parameter int   SPI_DATA_WIDTH = 8,
    parameter logic CPOL           = 1'b0,
    parameter logic CPHA           = 1'b0
) (
    input  logic clk,
    input  logic async_rst,
    input  logic p_clk,
    input  logic p_sel_n,
    input  logic copi,
    output logic poci,
    output logic poci_oe,
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    output logic overrun,
`endif
    spi_peripheral_if.slave host
);
    localparam int W  = SPI_DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    logic          sclk_s1, sclk_s2, sclk_s3;
    logic          sel_s1, sel_s2;
    logic          copi_s1, copi_s2;
    logic [1:0]    fill;
    logic          sel_seen;
    logic [W-1:0]  tx_sh, tx_buf, rx_sh, rx_next, rx_q;
    logic          tx_full, rx_vld_q, poci_q;
    logic [CW-1:0] bit_cnt;
    logic          lead, trail, sample, shift, run, last, load, start, abort;

    // sel_seen only sets once the synchroniser holds real pin history, so a select
    // already low when reset releases is not mistaken for a falling edge.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sclk_s1  <= CPOL;
            sclk_s2  <= CPOL;
            sclk_s3  <= CPOL;
            sel_s1   <= 1'b1;
            sel_s2   <= 1'b1;
            copi_s1  <= 1'b0;
            copi_s2  <= 1'b0;
            fill     <= 2'b00;
            sel_seen <= 1'b0;
        end else begin
            sclk_s1  <= p_clk;
            sclk_s2  <= sclk_s1;
            sclk_s3  <= sclk_s2;
            sel_s1   <= p_sel_n;
            sel_s2   <= sel_s1;
            copi_s1  <= copi;
            copi_s2  <= copi_s1;
            fill     <= {fill[0], 1'b1};
            sel_seen <= sel_seen | (fill[1] & sel_s2);
        end
    end

    assign lead    = (sclk_s2 != CPOL) && (sclk_s3 == CPOL);
    assign trail   = (sclk_s2 == CPOL) && (sclk_s3 != CPOL);
    assign sample  = CPHA ? trail : lead;
    assign shift   = CPHA ? lead : trail;
    assign run     = (state_q == ACTIVE) && !sel_s2;
    assign last    = run && sample && (bit_cnt == CW'(W - 1));
    assign load    = start || last;
    assign rx_next = {rx_sh[W-2:0], copi_s2};

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        abort     = 1'b0;
        poci_oe   = 1'b0;
        host.busy = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_seen && !sel_s2) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                poci_oe   = 1'b1;
                host.busy = 1'b1;
                if (sel_s2) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In mode CPHA=0 the trailing edge that follows a word's last sample must not
    // shift, because the next word's MSB has just been loaded onto poci.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            tx_sh   <= '0;
            tx_buf  <= '0;
            tx_full <= 1'b0;
            poci_q  <= 1'b0;
        end else begin
            if (load) begin
                tx_sh   <= tx_full ? tx_buf : '0;
                tx_full <= 1'b0;
            end else if (run && shift && (CPHA || (bit_cnt != '0))) begin
                poci_q <= tx_sh[W-1];
                tx_sh  <= {tx_sh[W-2:0], 1'b0};
            end
            if (host.tx_wr && !tx_full) begin
                tx_buf  <= host.tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            rx_sh    <= '0;
            bit_cnt  <= '0;
            rx_q     <= '0;
            rx_vld_q <= 1'b0;
        end else begin
            if (abort) begin
                rx_sh   <= '0;
                bit_cnt <= '0;
            end else if (run && sample) begin
                rx_sh   <= rx_next;
                bit_cnt <= last ? '0 : bit_cnt + 1'b1;
            end
            if (last) begin
                rx_q     <= rx_next;
                rx_vld_q <= 1'b1;
            end else if (host.rx_ack) begin
                rx_vld_q <= 1'b0;
            end
        end
    end

`ifdef SPI_PERIPHERAL_OVERRUN_EN
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst)                                overrun <= 1'b0;
        else if (last && rx_vld_q && !host.rx_ack)    overrun <= 1'b1;
        else if (host.rx_ack)                         overrun <= 1'b0;
    end
`endif

    assign host.tx_ready = !tx_full;
    assign host.rx_data  = rx_q;
    assign host.rx_valid = rx_vld_q;
    assign poci          = poci_oe ? (CPHA ? poci_q : tx_sh[W-1]) : 1'b0;
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed plus randomised bench: a mode-0 and a mode-3 peripheral driven by a behavioural SPI controller.
module tb_spi_peripheral;
    localparam int HALF = 80;

    logic clk = 1'b0;
    logic async_rst;
    logic pclk0, sel0, copi0, pclk3, sel3, copi3;
    wire  poci0, oe0, poci3, oe3;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    wire  ovr0, ovr3;
`endif

    int checks = 0;
    int errors = 0;

    initial forever #5 clk = ~clk;

    spi_peripheral_if #(.SPI_DATA_WIDTH(8)) h0 ();
    spi_peripheral_if #(.SPI_DATA_WIDTH(8)) h3 ();

    spi_peripheral #(.SPI_DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .async_rst(async_rst), .p_clk(pclk0), .p_sel_n(sel0), .copi(copi0),
        .poci(poci0), .poci_oe(oe0),
`ifdef SPI_PERIPHERAL_OVERRUN_EN
        .overrun(ovr0),
`endif
        .host(h0.slave)
    );

    spi_peripheral #(.SPI_DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
        .clk(clk), .async_rst(async_rst), .p_clk(pclk3), .p_sel_n(sel3), .copi(copi3),
        .poci(poci3), .poci_oe(oe3),
`ifdef SPI_PERIPHERAL_OVERRUN_EN
        .overrun(ovr3),
`endif
        .host(h3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mode 0 and mode 3 differ only in which pins and which idle level are used.
    task automatic set_clk(input int m, input logic v);
        if (m == 0) pclk0 = v; else pclk3 = v;
    endtask
    task automatic set_sel(input int m, input logic v);
        if (m == 0) sel0 = v; else sel3 = v;
    endtask
    task automatic set_copi(input int m, input logic v);
        if (m == 0) copi0 = v; else copi3 = v;
    endtask
    function automatic logic get_poci(input int m);
        return (m == 0) ? poci0 : poci3;
    endfunction
    function automatic logic get_oe(input int m);
        return (m == 0) ? oe0 : oe3;
    endfunction
    function automatic logic get_rxv(input int m);
        return (m == 0) ? h0.rx_valid : h3.rx_valid;
    endfunction
    function automatic logic [7:0] get_rxd(input int m);
        return (m == 0) ? h0.rx_data : h3.rx_data;
    endfunction
    function automatic logic get_txr(input int m);
        return (m == 0) ? h0.tx_ready : h3.tx_ready;
    endfunction
    function automatic logic get_busy(input int m);
        return (m == 0) ? h0.busy : h3.busy;
    endfunction

    task automatic host_write(input int m, input logic [7:0] d);
        @(negedge clk);
        if (m == 0) begin h0.tx_data = d; h0.tx_wr = 1'b1; end
        else        begin h3.tx_data = d; h3.tx_wr = 1'b1; end
        @(negedge clk);
        h0.tx_wr = 1'b0;
        h3.tx_wr = 1'b0;
    endtask

    task automatic select(input int m);
        @(negedge clk);
        set_sel(m, 1'b0);
        #HALF;
    endtask

    task automatic deselect(input int m);
        #HALF;
        set_sel(m, 1'b1);
        #HALF;
    endtask

    // Controller side: mode 0 samples poci on the leading edge, mode 3 on the trailing edge.
    task automatic clock_bits(input int m, input logic [7:0] dout, output logic [7:0] din,
                              input int nbits);
        logic cpol;
        cpol = (m == 3);
        din  = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (m == 0) begin
                set_copi(m, dout[7-i]);
                #HALF;
                set_clk(m, ~cpol);
                din[7-i] = get_poci(m);
                #HALF;
                set_clk(m, cpol);
            end else begin
                set_clk(m, ~cpol);
                set_copi(m, dout[7-i]);
                #HALF;
                din[7-i] = get_poci(m);
                set_clk(m, cpol);
                #HALF;
            end
        end
    endtask

    task automatic xfer(input int m, input logic [7:0] dout, output logic [7:0] din);
        select(m);
        clock_bits(m, dout, din, 8);
        deselect(m);
    endtask

    task automatic check_rx(input int m, input logic [7:0] exp, input string tag);
        repeat (6) @(negedge clk);
        chk({tag, "_rx_valid"}, get_rxv(m), 1'b1);
        chk({tag, "_rx_data"}, get_rxd(m), exp);
        if (m == 0) h0.rx_ack = 1'b1; else h3.rx_ack = 1'b1;
        @(negedge clk);
        h0.rx_ack = 1'b0;
        h3.rx_ack = 1'b0;
        chk({tag, "_rx_ack_clear"}, get_rxv(m), 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cap, d_ctl, d_per;
        int         m, wr;

        async_rst = 1'b1;
        pclk0 = 1'b0; sel0 = 1'b1; copi0 = 1'b0;
        pclk3 = 1'b1; sel3 = 1'b1; copi3 = 1'b0;
        h0.tx_data = '0; h0.tx_wr = 1'b0; h0.rx_ack = 1'b0;
        h3.tx_data = '0; h3.tx_wr = 1'b0; h3.rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", h0.tx_ready, 1'b1);
        chk("rst_rx_valid", h0.rx_valid, 1'b0);
        chk("rst_rx_data", h0.rx_data, 8'h00);
        chk("rst_busy", h0.busy, 1'b0);
        chk("rst_poci_oe", oe0, 1'b0);
        chk("rst_poci", poci0, 1'b0);
        async_rst = 1'b0;
        repeat (5) @(negedge clk);

        // Mode 0 single word.
        host_write(0, 8'hA5);
        chk("m0_tx_ready_full", h0.tx_ready, 1'b0);
        select(0);
        chk("m0_busy", h0.busy, 1'b1);
        chk("m0_poci_oe", oe0, 1'b1);
        clock_bits(0, 8'h3C, cap, 8);
        deselect(0);
        chk("m0_captured", cap, 8'hA5);
        chk("m0_tx_ready_back", h0.tx_ready, 1'b1);
        chk("m0_idle_busy", h0.busy, 1'b0);
        check_rx(0, 8'h3C, "m0");

        // Mode 3, two words under one select, buffer refilled after the first load.
        host_write(3, 8'h81);
        select(3);
        for (int i = 0; i < 20 && !h3.tx_ready; i++) @(negedge clk);
        chk("m3_tx_ready_after_load", h3.tx_ready, 1'b1);
        host_write(3, 8'h7E);
        clock_bits(3, 8'h7E, cap, 8);
        chk("m3_captured_w1", cap, 8'h81);
        check_rx(3, 8'h7E, "m3_w1");
        clock_bits(3, 8'h81, cap, 8);
        chk("m3_captured_w2", cap, 8'h7E);
        check_rx(3, 8'h81, "m3_w2");
        deselect(3);
        chk("m3_poci_oe_idle", oe3, 1'b0);

        // Empty TX buffer sends zeros.
        xfer(0, 8'h55, cap);
        chk("empty_captured", cap, 8'h00);
        check_rx(0, 8'h55, "empty");

        // A write while the buffer is full is dropped.
        host_write(3, 8'h5A);
        chk("ign_tx_ready", h3.tx_ready, 1'b0);
        host_write(3, 8'h33);
        xfer(3, 8'hE1, cap);
        chk("ign_captured", cap, 8'h5A);
        check_rx(3, 8'hE1, "ign");

        // Abort after five bits, then a clean word.
        select(0);
        clock_bits(0, 8'hFF, cap, 5);
        deselect(0);
        repeat (6) @(negedge clk);
        chk("abort_rx_valid", h0.rx_valid, 1'b0);
        chk("abort_busy", h0.busy, 1'b0);
        host_write(0, 8'h99);
        xfer(0, 8'hC3, cap);
        chk("post_abort_captured", cap, 8'h99);
        check_rx(0, 8'hC3, "post_abort");

        // Asynchronous reset mid-word, applied away from the clock edge.
        host_write(0, 8'h12);
        select(0);
        clock_bits(0, 8'hF0, cap, 3);
        host_write(0, 8'h34);
        chk("pre_rst_tx_ready", h0.tx_ready, 1'b0);
        @(posedge clk);
        #2;
        async_rst = 1'b1;
        #1;
        chk("midrst_poci", poci0, 1'b0);
        chk("midrst_poci_oe", oe0, 1'b0);
        chk("midrst_busy", h0.busy, 1'b0);
        chk("midrst_tx_ready", h0.tx_ready, 1'b1);
        chk("midrst_rx_valid", h0.rx_valid, 1'b0);
        chk("midrst_rx_data", h0.rx_data, 8'h00);
        @(negedge clk);
        async_rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_release_sel_low_busy", h0.busy, 1'b0);
        set_sel(0, 1'b1);
        #HALF;
        host_write(0, 8'h6B);
        xfer(0, 8'h96, cap);
        chk("post_rst_captured", cap, 8'h6B);
        check_rx(0, 8'h96, "post_rst");

        // Randomised words: peripheral sends the written word or zero, receives what was sent.
        for (int n = 0; n < 10; n++) begin
            m     = ($urandom_range(0, 1) == 0) ? 0 : 3;
            wr    = $urandom_range(0, 1);
            d_per = 8'($urandom);
            d_ctl = 8'($urandom);
            if (wr != 0) host_write(m, d_per);
            xfer(m, d_ctl, cap);
            chk("rand_captured", cap, (wr != 0) ? d_per : 8'h00);
            chk("rand_tx_ready", get_txr(m), 1'b1);
            chk("rand_oe_idle", get_oe(m), 1'b0);
            chk("rand_busy_idle", get_busy(m), 1'b0);
            check_rx(m, d_ctl, "rand");
        end

`ifdef SPI_PERIPHERAL_OVERRUN_EN
        xfer(0, 8'h11, cap);
        repeat (6) @(negedge clk);
        chk("ovr_first_clear", ovr0, 1'b0);
        xfer(0, 8'h22, cap);
        repeat (6) @(negedge clk);
        chk("ovr_set", ovr0, 1'b1);
        chk("ovr_rx_data", h0.rx_data, 8'h22);
        h0.rx_ack = 1'b1;
        @(negedge clk);
        h0.rx_ack = 1'b0;
        chk("ovr_cleared", ovr0, 1'b0);
        chk("ovr_rx_valid_cleared", h0.rx_valid, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
